// File: rtl/comm_rx_cmd_decoder.sv
// RX command decoder: turns 40-bit host frames into register-bus writes/reads and queues responses.
// Optional macro COMM_RX_ERR_RESP_EN: when defined, bad opcodes also produce an 0xEE error frame.
module comm_rx_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [39:0]          RX_Fifo_Data,
    input  logic                 RX_Fifo_Empty,
    output logic                 RX_Fifo_RE,
    output logic [15:0]          Reg_Addr,
    output logic [15:0]          Reg_WData,
    output logic                 Reg_WE,
    output logic                 Reg_RE,
    input  logic [15:0]          Reg_RData,
    input  logic                 Reg_RValid,
    output logic [39:0]          TX_Fifo_Data,
    output logic                 TX_Fifo_WE,
    input  logic                 TX_Fifo_Full,
    output logic [ERR_CNT_W-1:0] Err_Count,
    output logic                 Busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_WRITE    = 8'h01;
    localparam logic [7:0] OP_READ     = 8'h02;
    localparam logic [7:0] RSP_READ    = 8'h82;
    localparam logic [7:0] RSP_TIMEOUT = 8'hE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_Q,
        S_DECODE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_ERR_RESP,
        S_RESP
    } state_t;

    state_t                 r_state;
    logic [39:0]            r_frame;
    logic [15:0]            r_reg_addr;
    logic [15:0]            r_reg_wdata;
    logic                   r_reg_we;
    logic                   r_reg_re;
    logic [39:0]            r_tx_data;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]       r_to_cnt;

    logic [7:0]             w_opcode;
    logic [15:0]            w_addr;
    logic [15:0]            w_data;
    logic [ERR_CNT_W-1:0]   w_err_inc;

    assign w_opcode  = r_frame[39:32];
    assign w_addr    = r_frame[31:16];
    assign w_data    = r_frame[15:0];
    assign w_err_inc = (r_err_cnt == {ERR_CNT_W{1'b1}}) ? r_err_cnt : r_err_cnt + 1'b1;

    // The FIFO strobes must qualify on the same cycle's Empty/Full, so they are decoded from
    // the state register rather than registered; Reset masks the read strobe while held.
    assign RX_Fifo_RE = (r_state == S_IDLE) && !RX_Fifo_Empty && !Reset;
    assign TX_Fifo_WE = (r_state == S_RESP) && !TX_Fifo_Full;

    assign Reg_Addr     = r_reg_addr;
    assign Reg_WData    = r_reg_wdata;
    assign Reg_WE       = r_reg_we;
    assign Reg_RE       = r_reg_re;
    assign TX_Fifo_Data = r_tx_data;
    assign Err_Count    = r_err_cnt;
    assign Busy         = (r_state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_tx_data   <= '0;
            r_err_cnt   <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_reg_we <= 1'b0;
            r_reg_re <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!RX_Fifo_Empty) begin
                        r_state <= S_WAIT_Q;
                    end
                end

                S_WAIT_Q: begin
                    r_frame <= RX_Fifo_Data;
                    r_state <= S_DECODE;
                end

                S_DECODE: begin
                    case (w_opcode)
                        OP_WRITE: begin
                            r_reg_addr  <= w_addr;
                            r_reg_wdata <= w_data;
                            r_reg_we    <= 1'b1;
                            r_state     <= S_WRITE;
                        end
                        OP_READ: begin
                            r_reg_addr <= w_addr;
                            r_reg_re   <= 1'b1;
                            r_state    <= S_READ_REQ;
                        end
                        default: begin
                            r_err_cnt <= w_err_inc;
                            r_state   <= S_ERR_RESP;
                        end
                    endcase
                end

                S_WRITE: begin
                    r_state <= S_IDLE;
                end

                S_READ_REQ: begin
                    r_to_cnt <= '0;
                    r_state  <= S_READ_WAIT;
                end

                // Data arriving on the expiry cycle is checked first, so it wins over the timeout.
                S_READ_WAIT: begin
                    if (Reg_RValid) begin
                        r_tx_data <= {RSP_READ, w_addr, Reg_RData};
                        r_state   <= S_RESP;
                    end else if (r_to_cnt == CNT_LAST) begin
                        r_tx_data <= {RSP_TIMEOUT, w_addr, 16'h0000};
                        r_err_cnt <= w_err_inc;
                        r_state   <= S_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                S_ERR_RESP: begin
`ifdef COMM_RX_ERR_RESP_EN
                    r_tx_data <= {8'hEE, w_addr, 8'h00, w_opcode};
                    r_state   <= S_RESP;
`else
                    r_state   <= S_IDLE;
`endif
                end

                S_RESP: begin
                    if (!TX_Fifo_Full) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comm_rx_cmd_decoder.sv
// Scoreboard bench for comm_rx_cmd_decoder: directed frames, expected bus/TX events queued, monitor compares.
module tb_comm_rx_cmd_decoder;

    localparam int TO = 16;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [39:0] RX_Fifo_Data = '0;
    logic        RX_Fifo_Empty;
    logic        RX_Fifo_RE;
    logic [15:0] Reg_Addr;
    logic [15:0] Reg_WData;
    logic        Reg_WE;
    logic        Reg_RE;
    logic [15:0] Reg_RData = '0;
    logic        Reg_RValid = 1'b0;
    logic [39:0] TX_Fifo_Data;
    logic        TX_Fifo_WE;
    logic        TX_Fifo_Full;
    logic [7:0]  Err_Count;
    logic        Busy;

    comm_rx_cmd_decoder #(.TIMEOUT_CYCLES(TO), .ERR_CNT_W(8)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .RX_Fifo_Data (RX_Fifo_Data),
        .RX_Fifo_Empty(RX_Fifo_Empty),
        .RX_Fifo_RE   (RX_Fifo_RE),
        .Reg_Addr     (Reg_Addr),
        .Reg_WData    (Reg_WData),
        .Reg_WE       (Reg_WE),
        .Reg_RE       (Reg_RE),
        .Reg_RData    (Reg_RData),
        .Reg_RValid   (Reg_RValid),
        .TX_Fifo_Data (TX_Fifo_Data),
        .TX_Fifo_WE   (TX_Fifo_WE),
        .TX_Fifo_Full (TX_Fifo_Full),
        .Err_Count    (Err_Count),
        .Busy         (Busy)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        is_tx;
        logic [39:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          re_cnt = 0;
    int          rre_cyc = 0;
    int          txwe_cyc = 0;
    int          exp_err = 0;

    // RX FIFO model: frames written by stimulus, popped on RE, data valid the next cycle
    logic [39:0] rx_mem [0:511];
    int          rx_wr = 0;
    int          rx_rd = 0;
    assign RX_Fifo_Empty = (rx_wr == rx_rd);

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (RX_Fifo_RE) begin
            RX_Fifo_Data <= rx_mem[rx_rd];
            rx_rd        <= rx_rd + 1;
        end
    end

    // Register slave model: RValid rd_delay cycles after the Reg_RE cycle (0 = never)
    int          rd_delay = 0;
    logic [15:0] rd_data  = '0;
    int          rv_cnt   = 0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rv_cnt     <= 0;
            Reg_RValid <= 1'b0;
        end else begin
            Reg_RValid <= 1'b0;
            if (Reg_RE && rd_delay > 1) begin
                rv_cnt <= rd_delay - 1;
            end else if (rv_cnt > 0) begin
                if (rv_cnt == 1) begin
                    Reg_RValid <= 1'b1;
                    Reg_RData  <= rd_data;
                end
                rv_cnt <= rv_cnt - 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [39:0] f);
        rx_mem[rx_wr] = f;
        rx_wr++;
    endtask

    task automatic expect_evt(input logic is_tx, input logic [39:0] v);
        exp_t e;
        e.is_tx = is_tx;
        e.val   = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        logic stuck;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
            stuck = Busy || !RX_Fifo_Empty || (exp_q.size() != 0);
        end while (stuck && n < max_cyc);
        check(name, stuck, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a bus write or a TX frame
    always @(negedge Clock) begin
        if (!Reset) begin
            if (RX_Fifo_RE) begin
                re_cnt++;
                check("rx_re_while_empty", RX_Fifo_Empty, 0);
            end
            if (Reg_RE) rre_cyc = cyc;
            if (Reg_WE) begin
                check("reg_we_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("reg_we_kind", mon_e.is_tx, 0);
                    check("reg_we_frame", {8'h01, Reg_Addr, Reg_WData}, mon_e.val);
                end
            end
            if (TX_Fifo_WE) begin
                txwe_cyc = cyc;
                check("tx_we_while_full", TX_Fifo_Full, 0);
                check("tx_we_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("tx_kind", mon_e.is_tx, 1);
                    check("tx_frame", TX_Fifo_Data, mon_e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int start_rd;
        int k;
        int we_c[3];

        Reset        = 1'b1;
        TX_Fifo_Full = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset_outputs", {Reg_WE, Reg_RE, TX_Fifo_WE, RX_Fifo_RE, Busy}, 0);
        check("reset_buses", {Reg_Addr, Reg_WData, TX_Fifo_Data}, 0);
        check("reset_err", Err_Count, 0);
        Reset = 1'b0;
        @(negedge Clock);

        // Single WRITE
        expect_evt(1'b0, 40'h01_0010_ABCD);
        push_frame(40'h01_0010_ABCD);
        wait_idle("write_done", 20);
        check("write_re_count", re_cnt, 1);
        check("write_err", Err_Count, exp_err);

        // READ answered 3 cycles after Reg_RE
        rd_delay = 3;
        rd_data  = 16'h1234;
        expect_evt(1'b1, 40'h82_0020_1234);
        push_frame(40'h02_0020_0000);
        wait_idle("read_done", 30);
        check("read_latency", txwe_cyc - rre_cyc, 4);

        // READ timeout
        rd_delay = 0;
        expect_evt(1'b1, 40'hE1_0030_0000);
        push_frame(40'h02_0030_0000);
        wait_idle("timeout_done", 60);
        exp_err++;
        check("timeout_latency", txwe_cyc - rre_cyc, TO + 1);
        check("timeout_err", Err_Count, exp_err);

        // RValid on the expiry cycle: data wins, no error
        rd_delay = TO;
        rd_data  = 16'hBEEF;
        expect_evt(1'b1, 40'h82_0080_BEEF);
        push_frame(40'h02_0080_0000);
        wait_idle("tie_done", 60);
        check("tie_latency", txwe_cyc - rre_cyc, TO + 1);
        check("tie_err", Err_Count, exp_err);

        // Invalid opcode
`ifdef COMM_RX_ERR_RESP_EN
        expect_evt(1'b1, 40'hEE_0040_007F);
`endif
        push_frame(40'h7F_0040_0000);
        wait_idle("invalid_done", 20);
        exp_err++;
        check("invalid_err", Err_Count, exp_err);

        // TX FIFO full during a READ response; a WRITE waits behind it
        TX_Fifo_Full = 1'b1;
        rd_delay     = 2;
        rd_data      = 16'h5A5A;
        expect_evt(1'b1, 40'h82_0050_5A5A);
        expect_evt(1'b0, 40'h01_0060_1111);
        push_frame(40'h02_0050_0000);
        push_frame(40'h01_0060_1111);
        repeat (10) @(negedge Clock);
        start_rd = rx_rd;
        bad      = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (TX_Fifo_Data !== 40'h82_0050_5A5A || TX_Fifo_WE || rx_rd != start_rd) bad++;
        end
        check("full_hold_cycles_bad", bad, 0);
        check("full_busy", Busy, 1);
        check("full_next_not_read", RX_Fifo_Empty, 0);
        TX_Fifo_Full = 1'b0;
        wait_idle("full_done", 30);

        // Three back-to-back WRITEs
        expect_evt(1'b0, 40'h01_0100_0001);
        expect_evt(1'b0, 40'h01_0101_0002);
        expect_evt(1'b0, 40'h01_0102_0003);
        push_frame(40'h01_0100_0001);
        push_frame(40'h01_0101_0002);
        push_frame(40'h01_0102_0003);
        k = 0;
        for (int i = 0; i < 40 && k < 3; i++) begin
            @(negedge Clock);
            if (Reg_WE) begin
                we_c[k] = cyc;
                k++;
            end
        end
        check("b2b_we_count", k, 3);
        check("b2b_gap0", we_c[1] - we_c[0], 4);
        check("b2b_gap1", we_c[2] - we_c[1], 4);
        wait_idle("b2b_done", 20);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
`ifdef COMM_RX_ERR_RESP_EN
            expect_evt(1'b1, {8'hEE, 16'(i), 16'h0000});
`endif
            push_frame({8'h00, 16'(i), 16'h0000});
        end
        wait_idle("sat_done", 260 * 8);
        check("sat_err", Err_Count, 255);

        // Reset in READ_WAIT
        rd_delay = 0;
        push_frame(40'h02_0070_0000);
        repeat (8) @(negedge Clock);
        check("rst_busy_before", Busy, 1);
        Reset = 1'b1;
        #1;
        check("rst_mid_outputs", {Reg_WE, Reg_RE, TX_Fifo_WE, RX_Fifo_RE, Busy}, 0);
        check("rst_mid_buses", {Reg_Addr, Reg_WData, TX_Fifo_Data}, 0);
        check("rst_mid_err", Err_Count, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (30) @(negedge Clock);
        check("rst_after_busy", Busy, 0);
        check("rst_after_err", Err_Count, 0);

        check("rx_re_total", re_cnt, rx_wr);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
